spi_rx_ctrl: RTL and testbench
==============================

# spi_rx_ctrl

SPI read-path controller for the ILI9341 display link: the receive counterpart of the transmit shift controller. It runs a display read transaction (e.g. RDDID 0x04, RDDST 0x09) after the command byte has been sent. It drives `cs_n` and `sclk`, optionally issues dummy clocks, shifts `nbytes` bytes MSB-first in from the panel's SDO line, and hands each byte upstream over a valid/ready handshake. Sits beside the transmit controller under the display top level; the top level muxes `sclk`/`cs_n` between the two.

## Interface
Parameters:
- `CLK_DIV`, 2: `sclk` half-period in `clk` cycles; legal range 1 to 255.
- `MAX_BYTES`, 4: maximum bytes per read; `NB_W = $clog2(MAX_BYTES+1)`.
- `DUMMY_BITS`, 1: dummy `sclk` cycles before the first data bit; used only with `SPI_RX_DUMMY_EN`.

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: reset. Synchronous, active-low.
- `start` in 1: one-cycle request; accepted only in IDLE with `nbytes != 0`.
- `nbytes` in NB_W: byte count, sampled on accepted `start`; values above `MAX_BYTES` are clamped to `MAX_BYTES`.
- `miso` in 1: panel SDO, already synchronised to `clk`.
- `rx_ready` in 1: upstream ready.
- `cs_n` out 1: chip select, active-low, registered.
- `sclk` out 1: SPI clock, registered from `clk`. Mode 0, idle low. Never a gated clock.
- `rx_data` out 8: received byte; stable while `rx_valid` is high.
- `rx_valid` out 1: byte available.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle pulse at the end of a transaction.

## Operation
- **States:** IDLE, DUMMY, SHIFT, HOLD, DONE.
- **IDLE:** `cs_n`=1, `sclk`=0, `busy`=0. On accepted `start`:
  - latch the clamped count;
  - go to DUMMY if the macro is defined and `DUMMY_BITS>0`; otherwise go to SHIFT.
- **Bit period:** `2*CLK_DIV` cycles, low phase first, then high phase.
  - A divider counts 0..CLK_DIV-1 and toggles `sclk` at terminal count.
  - On the toggle 0->1, `miso` is sampled at that same clk edge and shifted into bit 0 of the shift register (MSB first overall).
- **DUMMY:** issues `DUMMY_BITS` full bit periods. Samples are discarded. Then goes to SHIFT.
- **SHIFT:** issues 8 bit periods. After the 8th high phase ends (`sclk` back to 0):
  - load `rx_data`;
  - set `rx_valid`;
  - go to HOLD.
- **HOLD:** `sclk` held 0, `cs_n` held 0.
  - Waits for `rx_valid && rx_ready`. On handshake `rx_valid` drops next cycle.
  - If more bytes remain, go to SHIFT; no dummy clocks between bytes.
  - If no bytes remain, go to DONE.
- **DONE:** `cs_n`=1, `done`=1 for one cycle, then IDLE.
- **Per-state outputs:**
  - `busy`=1 in DUMMY, SHIFT, HOLD and DONE.
  - `cs_n`=0 in DUMMY, SHIFT and HOLD.
- **Counters:** the byte counter decrements on each handshake. The bit counter (3-bit) wraps 7->0 per byte and is cleared on entry to SHIFT.
- **Ignored inputs:** `start` while `busy` is ignored. `start` with `nbytes==0` is ignored (no state change, no `done`).
- **Reset:** `rst`=0 at any clk edge forces IDLE on that edge. Any partial byte is discarded.
- **Reset values:** `cs_n`=1, `sclk`=0, `rx_data`=8'h00, `rx_valid`=0, `busy`=0, `done`=0. All counters cleared.

## Timing
- Take cycle 0 as the cycle in which `start` is accepted. State is DUMMY/SHIFT from cycle 1, and `cs_n` falls at cycle 1.
- The first `sclk` rise occurs at cycle `1+CLK_DIV`.
- With no dummy and `CLK_DIV`=2, for one byte:
  - SHIFT occupies cycles 1..32;
  - `rx_valid` is high from cycle 33;
  - with `rx_ready`=1, the handshake is at 33 and `done`=1 at cycle 34;
  - IDLE and `cs_n`=1 hold from 35.
- Each dummy bit adds `2*CLK_DIV` cycles before the first byte.
- Each HOLD cycle without `rx_ready` adds one cycle. During a stall `sclk` stays low and `rx_data` holds its value.
- Minimum per extra byte: one HOLD cycle plus `16*CLK_DIV`.

## Configuration
- `SPI_RX_DUMMY_EN` defined: the DUMMY state and `DUMMY_BITS` are compiled in. This matches the ILI9341 multi-byte reads that need one dummy clock.
- Not defined: the DUMMY state is absent and `DUMMY_BITS` is ignored. SHIFT follows IDLE directly, and the first `sclk` rise samples data bit 7.

## Test plan
- **Reset values:** hold `rst`=0 for 3 cycles with `start`=1. Required: `cs_n`=1, `sclk`=0, `rx_data`=8'h00, `rx_valid`/`busy`/`done`=0 throughout.
- **Single byte, no dummy:** `CLK_DIV`=2, macro off, `nbytes`=1, panel drives 0xA5, `rx_ready`=1. Required:
  - exactly 8 `sclk` rises;
  - `rx_data`=0xA5 with `rx_valid` at cycle 33;
  - `done` at 34;
  - `cs_n` low over cycles 1..33.
- **Read ID with dummy:** macro on, `DUMMY_BITS`=1, `nbytes`=3, panel drives dummy 1 then 0x00, 0x93, 0x41. Required:
  - 25 `sclk` rises;
  - three handshakes delivering 0x00, 0x93, 0x41;
  - one `done` pulse.
- **Backpressure:** `nbytes`=2, bytes 0x3C and 0xC3, `rx_ready`=0 for 10 cycles after the first `rx_valid`. Required:
  - `sclk`=0, `cs_n`=0 and `rx_data`=0x3C stable during the stall;
  - second byte 0xC3 received correctly after the handshake.
- **Reset mid-byte:** assert `rst`=0 after 4 `sclk` rises. Required:
  - all outputs at reset values on the next cycle;
  - a subsequent 1-byte read of 0x5A returns 0x5A.
- **Ignored and clamped requests:**
  - `start` with `nbytes`=0 is ignored: no `busy`, no `done`;
  - `start` pulsed while `busy` has no effect;
  - `nbytes`=7 with `MAX_BYTES`=4 yields exactly 4 handshakes.

Source files
------------

// File: rtl/spi_rx_ctrl.sv
// spi_rx_ctrl: SPI mode-0 read-path controller for the ILI9341 display link.
// Define SPI_RX_DUMMY_EN to issue DUMMY_BITS dummy clocks before the data.
module spi_rx_ctrl #(
    parameter int  CLK_DIV    = 2,
    parameter int  MAX_BYTES  = 4,
    parameter int  DUMMY_BITS = 1,
    localparam int NB_W       = $clog2(MAX_BYTES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [NB_W-1:0] nbytes,
    input  logic            miso,
    input  logic            rx_ready,
    output logic            cs_n,
    output logic            sclk,
    output logic [7:0]      rx_data,
    output logic            rx_valid,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef SPI_RX_DUMMY_EN
        S_DUMMY,
`endif
        S_SHIFT,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [7:0]      DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [NB_W-1:0] MAX_NB   = NB_W'(MAX_BYTES);

    state_t          state_q, state_d;
    logic [7:0]      div_q, div_d;
    logic            sclk_q, sclk_d;
    logic [2:0]      bit_q, bit_d;
    logic [NB_W-1:0] bytes_q, bytes_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            cs_n_q, cs_n_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tc;
    logic [NB_W-1:0] nb_clamped;

`ifdef SPI_RX_DUMMY_EN
    localparam int            DW         = (DUMMY_BITS > 1) ? $clog2(DUMMY_BITS) : 1;
    localparam logic [DW-1:0] DUMMY_LAST = DW'(DUMMY_BITS - 1);

    logic [DW-1:0] dummy_q, dummy_d;
`else
    logic unused_dummy_bits;
    assign unused_dummy_bits = |DUMMY_BITS;
`endif

    assign tc         = (div_q == DIV_LAST);
    assign nb_clamped = (nbytes > MAX_NB) ? MAX_NB : nbytes;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        sclk_d     = sclk_q;
        bit_d      = bit_q;
        bytes_d    = bytes_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
`ifdef SPI_RX_DUMMY_EN
        dummy_d    = dummy_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                sclk_d = 1'b0;
                div_d  = '0;
                if (start && (nbytes != '0)) begin
                    bytes_d = nb_clamped;
                    bit_d   = '0;
`ifdef SPI_RX_DUMMY_EN
                    dummy_d = '0;
                    state_d = (DUMMY_BITS > 0) ? S_DUMMY : S_SHIFT;
`else
                    state_d = S_SHIFT;
`endif
                end
            end
`ifdef SPI_RX_DUMMY_EN
            S_DUMMY: begin
                div_d  = tc ? '0 : div_q + 8'd1;
                sclk_d = sclk_q ^ tc;
                // samples taken during dummy clocks are thrown away
                if (tc && sclk_q) begin
                    if (dummy_q == DUMMY_LAST) begin
                        state_d = S_SHIFT;
                        bit_d   = '0;
                    end else begin
                        dummy_d = dummy_q + 1'b1;
                    end
                end
            end
`endif
            S_SHIFT: begin
                div_d  = tc ? '0 : div_q + 8'd1;
                sclk_d = sclk_q ^ tc;
                if (tc && !sclk_q) begin
                    shift_d = {shift_q[6:0], miso};
                end else if (tc && sclk_q) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                sclk_d = 1'b0;
                if (rx_valid_q && rx_ready) begin
                    rx_valid_d = 1'b0;
                    bytes_d    = bytes_q - 1'b1;
                    div_d      = '0;
                    bit_d      = '0;
                    state_d    = (bytes_q == NB_W'(1)) ? S_DONE : S_SHIFT;
                end
            end
            S_DONE: begin
                sclk_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // outputs are registered straight from the next state
    assign cs_n_d = (state_d == S_IDLE) || (state_d == S_DONE);
    assign busy_d = (state_d != S_IDLE);
    assign done_d = (state_d == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            sclk_q     <= 1'b0;
            bit_q      <= '0;
            bytes_q    <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SPI_RX_DUMMY_EN
            dummy_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            sclk_q     <= sclk_d;
            bit_q      <= bit_d;
            bytes_q    <= bytes_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef SPI_RX_DUMMY_EN
            dummy_q    <= dummy_d;
`endif
        end
    end

    assign cs_n     = cs_n_q;
    assign sclk     = sclk_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_spi_rx_ctrl.sv
// tb_spi_rx_ctrl: randomized self-checking bench for spi_rx_ctrl.
// Panel model and timing reference are built from byte/bit-period arithmetic.
module tb_spi_rx_ctrl;

    localparam int D    = 2;
    localparam int MAXB = 4;
    localparam int DB   = 1;
    localparam int NB_W = $clog2(MAXB + 1);
`ifdef SPI_RX_DUMMY_EN
    localparam int ND = DB;
`else
    localparam int ND = 0;
`endif
    localparam int LN = 1024;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [NB_W-1:0] nbytes = '0;
    logic            miso = 1'b0;
    logic            rx_ready = 1'b0;
    logic            cs_n, sclk, rx_valid, busy, done;
    logic [7:0]      rx_data;

    spi_rx_ctrl #(
        .CLK_DIV(D),
        .MAX_BYTES(MAXB),
        .DUMMY_BITS(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .nbytes(nbytes),
        .miso(miso),
        .rx_ready(rx_ready),
        .cs_n(cs_n),
        .sclk(sclk),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rises = 0;
    int base = 0;
    int t0 = 1 << 30;
    int done_n = 0;
    int done_base = 0;
    logic sclk_prev = 1'b0;

    bit         stream[$];
    logic [7:0] tx_bytes[$];
    logic [7:0] got[$];
    int         hs[$];
    int         exp_hs[$];
    int         exp_done;

    bit         ready_pat[LN];
    logic       sclk_log[LN];
    logic       cs_log[LN];
    logic       valid_log[LN];
    logic       busy_log[LN];
    logic       done_log[LN];
    logic [7:0] data_log[LN];

    // Panel + observer: counts sclk rises, records handshakes, drives SDO.
    always @(negedge clk) begin
        int rel;
        int idx;
        cyc++;
        if (sclk === 1'b1 && sclk_prev === 1'b0) rises++;
        sclk_prev = sclk;
        rel = cyc - t0;
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            got.push_back(rx_data);
            hs.push_back(rel);
        end
        if (done === 1'b1) done_n++;
        if (rel >= 0 && rel < LN) begin
            sclk_log[rel]  = sclk;
            cs_log[rel]    = cs_n;
            valid_log[rel] = rx_valid;
            busy_log[rel]  = busy;
            done_log[rel]  = done;
            data_log[rel]  = rx_data;
        end
        idx = rises - base;
        miso = (idx >= 0 && idx < stream.size()) ? stream[idx] : 1'b0;
    end

    task automatic load_stream();
        stream.delete();
        for (int i = 0; i < ND; i++) stream.push_back(1'b1);
        foreach (tx_bytes[i])
            for (int k = 7; k >= 0; k--) stream.push_back(tx_bytes[i][k]);
    endtask

    task automatic fill_ready(input int pct);
        for (int c = 0; c < LN; c++)
            ready_pat[c] = ($urandom_range(0, 99) < pct);
    endtask

    // Reference: each byte costs 16*D shift cycles then waits in HOLD for ready.
    task automatic model(input int n);
        int t;
        int nn;
        nn = (n > MAXB) ? MAXB : n;
        exp_hs.delete();
        t = ND * 2 * D;
        for (int k = 0; k < nn; k++) begin
            t += 16 * D + 1;
            while (t < LN - 1 && !ready_pat[t]) t++;
            exp_hs.push_back(t);
        end
        exp_done = t + 1;
    endtask

    task automatic run_read(input int n, input int restart_at, output bit ok);
        int post;
        post = 0;
        ok = 1'b0;
        @(posedge clk);
        #1;
        got.delete();
        hs.delete();
        base = rises;
        done_base = done_n;
        t0 = cyc + 1;
        start = 1'b1;
        nbytes = NB_W'(n);
        rx_ready = ready_pat[0];
        for (int c = 1; c < LN - 8; c++) begin
            @(posedge clk);
            #1;
            start = (c == restart_at);
            if (start) nbytes = NB_W'(3);
            rx_ready = ready_pat[c];
            if (done_n != done_base) post++;
            if (post == 3) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b1;
        nbytes = NB_W'(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (cs_n !== 1'b1) begin
                failures++;
                $display("FAIL reset_cs_n got=%b exp=1", cs_n);
            end
            checks++;
            if (sclk !== 1'b0) begin
                failures++;
                $display("FAIL reset_sclk got=%b exp=0", sclk);
            end
            checks++;
            if (rx_data !== 8'h00) begin
                failures++;
                $display("FAIL reset_rx_data got=%h exp=00", rx_data);
            end
            checks++;
            if ({rx_valid, busy, done} !== 3'b000) begin
                failures++;
                $display("FAIL reset_flags got=%b exp=000", {rx_valid, busy, done});
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single_byte();
        bit ok;
        int bad_cs;
        tx_bytes = {8'hA5};
        load_stream();
        fill_ready(100);
        model(1);
        run_read(1, -1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_timeout got=no_done exp=done");
        end
        checks++;
        if (rises - base !== ND + 8) begin
            failures++;
            $display("FAIL single_rises got=%0d exp=%0d", rises - base, ND + 8);
        end
        checks++;
        if (got.size() !== 1) begin
            failures++;
            $display("FAIL single_count got=%0d exp=1", got.size());
        end else begin
            checks++;
            if (got[0] !== 8'hA5) begin
                failures++;
                $display("FAIL single_data got=%h exp=a5", got[0]);
            end
            checks++;
            if (hs[0] !== exp_hs[0]) begin
                failures++;
                $display("FAIL single_hs_cycle got=%0d exp=%0d", hs[0], exp_hs[0]);
            end
        end
        checks++;
        if (valid_log[exp_hs[0] - 1] !== 1'b0 || valid_log[exp_hs[0]] !== 1'b1) begin
            failures++;
            $display("FAIL single_valid_edge got=%b%b exp=01",
                     valid_log[exp_hs[0] - 1], valid_log[exp_hs[0]]);
        end
        checks++;
        if (done_log[exp_done] !== 1'b1 || done_log[exp_done - 1] !== 1'b0) begin
            failures++;
            $display("FAIL single_done_cycle got=%b%b exp=01",
                     done_log[exp_done - 1], done_log[exp_done]);
        end
        bad_cs = 0;
        for (int c = 1; c <= exp_hs[0]; c++) if (cs_log[c] !== 1'b0) bad_cs++;
        if (cs_log[0] !== 1'b1 || cs_log[exp_done] !== 1'b1) bad_cs++;
        if (cs_log[exp_done + 1] !== 1'b1) bad_cs++;
        checks++;
        if (bad_cs !== 0) begin
            failures++;
            $display("FAIL single_cs_window got=%0d_bad_cycles exp=0", bad_cs);
        end
        checks++;
        if (busy_log[exp_done] !== 1'b1 || busy_log[exp_done + 1] !== 1'b0) begin
            failures++;
            $display("FAIL single_busy_end got=%b%b exp=10",
                     busy_log[exp_done], busy_log[exp_done + 1]);
        end
    endtask

    task automatic test_read_id();
        bit ok;
        tx_bytes = {8'h00, 8'h93, 8'h41};
        load_stream();
        fill_ready(100);
        model(3);
        run_read(3, -1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL readid_timeout got=no_done exp=done");
        end
        checks++;
        if (rises - base !== ND + 24) begin
            failures++;
            $display("FAIL readid_rises got=%0d exp=%0d", rises - base, ND + 24);
        end
        checks++;
        if (got.size() !== 3) begin
            failures++;
            $display("FAIL readid_count got=%0d exp=3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== tx_bytes[i] || hs[i] !== exp_hs[i]) begin
                    failures++;
                    $display("FAIL readid_byte%0d got=%h@%0d exp=%h@%0d",
                             i, got[i], hs[i], tx_bytes[i], exp_hs[i]);
                end
            end
        end
        checks++;
        if (done_n - done_base !== 1) begin
            failures++;
            $display("FAIL readid_done_pulses got=%0d exp=1", done_n - done_base);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int h1;
        tx_bytes = {8'h3C, 8'hC3};
        load_stream();
        fill_ready(100);
        h1 = ND * 2 * D + 16 * D + 1;
        for (int c = h1; c < h1 + 10; c++) ready_pat[c] = 1'b0;
        model(2);
        run_read(2, -1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_timeout got=no_done exp=done");
        end
        for (int c = h1; c < h1 + 10; c++) begin
            checks++;
            if ({sclk_log[c], cs_log[c], valid_log[c]} !== 3'b001 ||
                data_log[c] !== 8'h3C) begin
                failures++;
                $display("FAIL bp_stall_c%0d got=sclk%b_cs%b_v%b_%h exp=sclk0_cs0_v1_3c",
                         c, sclk_log[c], cs_log[c], valid_log[c], data_log[c]);
            end
        end
        checks++;
        if (got.size() !== 2) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=2", got.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got[i] !== tx_bytes[i] || hs[i] !== exp_hs[i]) begin
                    failures++;
                    $display("FAIL bp_byte%0d got=%h@%0d exp=%h@%0d",
                             i, got[i], hs[i], tx_bytes[i], exp_hs[i]);
                end
            end
        end
        checks++;
        if (done_log[exp_done] !== 1'b1) begin
            failures++;
            $display("FAIL bp_done_cycle got=%b exp=1", done_log[exp_done]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        tx_bytes = {8'hFF};
        load_stream();
        fill_ready(100);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        base = rises;
        start = 1'b1;
        nbytes = NB_W'(1);
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (rises - base < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rises - base !== 4) begin
            failures++;
            $display("FAIL midrst_rises got=%0d exp=4", rises - base);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cs_n, sclk, rx_valid, busy, done} !== 5'b10000 || rx_data !== 8'h00) begin
            failures++;
            $display("FAIL midrst_outputs got=%b_%h exp=10000_00",
                     {cs_n, sclk, rx_valid, busy, done}, rx_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        tx_bytes = {8'h5A};
        load_stream();
        model(1);
        run_read(1, -1, ok);
        checks++;
        if (!ok || got.size() !== 1) begin
            failures++;
            $display("FAIL midrst_reread got=ok%0d_n%0d exp=ok1_n1", ok, got.size());
        end else begin
            checks++;
            if (got[0] !== 8'h5A) begin
                failures++;
                $display("FAIL midrst_data got=%h exp=5a", got[0]);
            end
        end
    endtask

    task automatic test_ignored_clamped();
        bit ok;
        int seen;
        int d0;
        d0 = done_n;
        @(posedge clk);
        #1;
        start = 1'b1;
        nbytes = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || cs_n !== 1'b1 || sclk !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0 || done_n !== d0) begin
            failures++;
            $display("FAIL zero_start got=active%0d_done%0d exp=0_0", seen, done_n - d0);
        end
        tx_bytes = {8'h77, 8'h11, 8'h22};
        load_stream();
        fill_ready(100);
        model(1);
        run_read(1, 10, ok);
        checks++;
        if (!ok || got.size() !== 1 || done_n - done_base !== 1) begin
            failures++;
            $display("FAIL busy_start got=ok%0d_n%0d_d%0d exp=ok1_n1_d1",
                     ok, got.size(), done_n - done_base);
        end else begin
            checks++;
            if (got[0] !== 8'h77 || done_log[exp_done] !== 1'b1) begin
                failures++;
                $display("FAIL busy_start_data got=%h_%b exp=77_1",
                         got[0], done_log[exp_done]);
            end
        end
        tx_bytes = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        load_stream();
        model(7);
        run_read(7, -1, ok);
        checks++;
        if (!ok || got.size() !== MAXB) begin
            failures++;
            $display("FAIL clamp_count got=ok%0d_n%0d exp=ok1_n%0d", ok, got.size(), MAXB);
        end
        checks++;
        if (rises - base !== ND + 8 * MAXB) begin
            failures++;
            $display("FAIL clamp_rises got=%0d exp=%0d", rises - base, ND + 8 * MAXB);
        end
    endtask

    task automatic test_random();
        bit ok;
        int n;
        for (int it = 0; it < 5; it++) begin
            n = $urandom_range(1, MAXB);
            tx_bytes.delete();
            for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
            load_stream();
            fill_ready(65);
            model(n);
            run_read(n, -1, ok);
            checks++;
            if (!ok || got.size() !== n) begin
                failures++;
                $display("FAIL rand%0d_count got=ok%0d_n%0d exp=ok1_n%0d",
                         it, ok, got.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (got[i] !== tx_bytes[i] || hs[i] !== exp_hs[i]) begin
                        failures++;
                        $display("FAIL rand%0d_byte%0d got=%h@%0d exp=%h@%0d",
                                 it, i, got[i], hs[i], tx_bytes[i], exp_hs[i]);
                    end
                end
            end
            checks++;
            if (done_log[exp_done] !== 1'b1 || rises - base !== ND + 8 * n) begin
                failures++;
                $display("FAIL rand%0d_end got=done%b_rises%0d exp=done1_rises%0d",
                         it, done_log[exp_done], rises - base, ND + 8 * n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_read_id();
        test_backpressure();
        test_reset_mid();
        test_ignored_clamped();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
